// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------+
// | alu_pkg : op codes, error codes, states and flag layout        |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_MUL = 3'd4
  } op_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_OVF     = 3'd1;
  localparam logic [2:0] ERR_MUL_OVF = 3'd2;
  localparam logic [2:0] ERR_BAD_OP  = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f      = '0;
    f[F_N] = n;
    f[F_Z] = z;
    f[F_C] = c;
    f[F_V] = v;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// +----------------------------------------------------------------+
// | alu_mul_seq : unsigned shift-add multiplier, one bit per cycle |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_prod_nxt;

  assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_prod   <= '0;
      r_mplier <= b;
      r_cnt    <= CNT_W'(WIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  // done flags the final iteration; product then already shows its outcome
  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == CNT_W'(1));
  assign product = r_busy ? w_prod_nxt : r_prod;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +----------------------------------------------------------------+
// | alu_seq : handshaked registered ALU with N/Z/C/V and error code |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [2:0]       error
);

  localparam int MSB = WIDTH - 1;
  localparam logic [OP_W-1:0] c_OP_ADD = OP_W'(OP_ADD);
  localparam logic [OP_W-1:0] c_OP_SUB = OP_W'(OP_SUB);
  localparam logic [OP_W-1:0] c_OP_AND = OP_W'(OP_AND);
  localparam logic [OP_W-1:0] c_OP_OR  = OP_W'(OP_OR);
  localparam logic [OP_W-1:0] c_OP_MUL = OP_W'(OP_MUL);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic [2:0]         r_error;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_mul_ovf;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [2:0]         w_err;

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign flags     = r_flags;
  assign error     = r_error;

  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = (op == c_OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_accept && w_is_mul),
    .a       (a),
    .b       (b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_prod)
  );

  assign w_mul_ovf = |w_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_is_mul ? EXEC : DONE;
      // an idle multiplier that never signalled done cannot finish; bail out
      EXEC: begin
        if (w_mul_done)       w_state_nxt = DONE;
        else if (!w_mul_busy) w_state_nxt = IDLE;
      end
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = ERR_NONE;
    case (op)
      c_OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      c_OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      c_OP_AND: w_res = a & b;
      c_OP_OR:  w_res = a | b;
      c_OP_MUL: w_res = '0;
      default:  w_err = ERR_BAD_OP;
    endcase
    if (w_v) w_err = ERR_OVF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_flags  <= '0;
      r_error  <= ERR_NONE;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_flags  <= pack_flags(w_res[MSB], w_res == '0, w_c, w_v);
      r_error  <= w_err;
    end else if ((r_state == EXEC) && w_mul_done) begin
      r_result <= w_prod[WIDTH-1:0];
      r_flags  <= pack_flags(w_prod[MSB], w_prod[WIDTH-1:0] == '0, w_mul_ovf, w_mul_ovf);
      r_error  <= w_mul_ovf ? ERR_MUL_OVF : ERR_NONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +----------------------------------------------------------------+
// | tb_alu_seq : scoreboard bench for alu_seq with arithmetic model |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  result;
  logic [3:0]    flags;
  logic [2:0]    error;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
    logic [2:0]  e;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   seen = 1'b0;

  alu_seq #(.WIDTH(W), .OP_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .error     (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [2:0] o);
    exp_t        e;
    longint      full;
    int          sr;
    logic [15:0] r;
    logic        c, v;
    logic [2:0]  er;
    full = 0; sr = 0; r = '0; c = 1'b0; v = 1'b0; er = 3'd0;
    case (o)
      3'd0: begin
        full = longint'(x) + longint'(y);
        r = full[15:0];
        c = (full > 65535);
        sr = int'($signed(x)) + int'($signed(y));
        v = (sr > 32767) || (sr < -32768);
        er = v ? 3'd1 : 3'd0;
      end
      3'd1: begin
        full = longint'(x) - longint'(y);
        r = full[15:0];
        c = (x < y);
        sr = int'($signed(x)) - int'($signed(y));
        v = (sr > 32767) || (sr < -32768);
        er = v ? 3'd1 : 3'd0;
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: begin
        full = longint'(x) * longint'(y);
        r = full[15:0];
        c = (full > 65535);
        v = c;
        er = c ? 3'd2 : 3'd0;
      end
      default: er = 3'd3;
    endcase
    e.r = r;
    e.f = {r[15], (r == 16'h0), c, v};
    e.e = er;
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!out_valid) seen = 1'b0;
    else if (!seen) begin
      seen = 1'b1;
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", result, e.r);
        chk("flags", flags, e.f);
        chk("error", error, e.e);
        chk("latency", cyc - e.acc, e.lat);
        chk("in_ready_while_done", in_ready, 0);
      end
    end
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2,
                        input logic [2:0] to, input int hold);
    exp_t ex;
    int   n;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
    ex = model(ta, tb2, to);
    ex.acc = cyc;
    ex.lat = (to == 3'd4) ? W + 1 : 1;
    q.push_back(ex);
    a = ta; b = tb2; op = to; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      q.delete();
      out_ready = 1'b1;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin a = 16'h0001; b = 16'h0001; op = 3'd0; in_valid = 1'b1; end
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, ex.r);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    run_op(16'h7FFF, 16'h0001, 3'd0, 2);
    run_op(16'h0003, 16'h0005, 3'd1, 0);
    run_op(16'hFFFF, 16'h0001, 3'd0, 0);
    run_op(16'd300,  16'd200,  3'd4, 0);
    run_op(16'd256,  16'd256,  3'd4, 1);
    run_op(16'h00F0, 16'h0F00, 3'd3, 5);
    run_op(16'h7FFF, 16'h0001, 3'd0, 0);

    // abort a multiply part-way through with an asynchronous reset
    a = 16'd300; b = 16'd200; op = 3'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", flags, 0);
    chk("abort_error", error, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);

    run_op(16'hF0F0, 16'h0FF0, 3'd2, 0);
    run_op(16'h1234, 16'h5678, 3'd7, 0);

    for (int i = 0; i < 60; i++) begin
      run_op(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end
    run_op(16'hFFFF, 16'hFFFF, 3'd4, 0);
    run_op(16'h8000, 16'h0001, 3'd1, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the calculator's combinational ALU.
- Accepts one operation per handshake: add, sub, and, or, or multi-cycle unsigned multiply.
- Returns the result with N/Z/C/V flags and a 3-bit error code that drives the board RGB LED.
- Sits between the calculator input FSM (operand/op capture) and the display/RGB drivers.

Parameters:
- WIDTH, 16, operand and result width in bits (must be >= 4).
- OP_W, 3, width of the op code.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  a, b and op are valid this cycle.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  OP_W  0=ADD, 1=SUB, 2=AND, 3=OR, 4=MUL, 5..7 invalid.
- out_valid  output  1  result, flags and error are valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- flags  output  4  {N,Z,C,V}, registered.
- error  output  3  0=none, 1=signed overflow, 2=multiply overflow, 3=invalid op.

Behaviour:
- Reset (async, any state): state=IDLE; result, flags and error all 0; out_valid=0; in_ready=1 once reset deasserts.
- States: IDLE, EXEC, DONE.
- in_ready=1 only in IDLE; out_valid=1 only in DONE.
- Accept occurs when in_valid && in_ready at a rising edge; a, b and op are captured internally.
- IDLE + accept, op != MUL: the result is computed and registered in the same edge; next state is DONE. Latency: out_valid high 1 cycle after accept.
- IDLE + accept, op == MUL: the multiplier is loaded; next state is EXEC.
  - EXEC runs WIDTH shift-add iterations, one per cycle, over a 2*WIDTH-bit product.
  - After the last iteration: result=low WIDTH bits, then DONE. out_valid is high WIDTH+1 cycles after accept.
- DONE: result, flags and error are held stable while out_ready=0. On out_ready=1 the block goes to IDLE; in_ready rises the next cycle (no same-cycle re-accept).
- in_valid outside IDLE is ignored; operands are not buffered.
- ADD: r=a+b. C=carry out. V=(a[msb]==b[msb]) && (r[msb]!=a[msb]). error=1 if V.
- SUB: r=a-b. C=borrow (1 when a<b unsigned). V=(a[msb]!=b[msb]) && (r[msb]!=a[msb]). error=1 if V.
- AND/OR: bitwise; C=0, V=0, error=0.
- MUL: unsigned. C=V=(upper WIDTH product bits != 0). error=2 if V.
- Invalid op: result=0, Z=1, N=C=V=0, error=3. Still passes through DONE with 1-cycle latency.
- N=r[WIDTH-1] and Z=(r==0) for every op.
- Reset during EXEC or DONE aborts the operation with no partial result visible; out_valid drops immediately (async).

Decomposition:
- Package alu_pkg holds:
  - op_t enum (OP_ADD..OP_MUL).
  - err_t constants (ERR_NONE, ERR_OVF, ERR_MUL_OVF, ERR_BAD_OP).
  - state_t enum (IDLE, EXEC, DONE).
  - flag bit index constants (F_N=3, F_Z=2, F_C=1, F_V=0).
- One sub-module: alu_mul_seq, the shift-add multiplier.
  - Ports: clk, reset, start, a, b, busy, done (1-cycle pulse), product[2*WIDTH-1:0].
  - The top FSM owns the handshake; alu_mul_seq owns the iteration counter.

Test Plan (WIDTH=16):
- ADD a=0x7FFF, b=0x0001 -> one cycle after accept: result=0x8000, flags N=1 Z=0 C=0 V=1, error=1; in_ready=0 until out_ready.
- SUB a=3, b=5 -> result=0xFFFE, N=1, C=1, V=0, error=0. Then ADD a=0xFFFF, b=0x0001 -> result=0x0000, Z=1, C=1, V=0, error=0.
- MUL a=300, b=200 -> out_valid exactly 17 cycles after accept, result=0xEA60, error=0. MUL a=256, b=256 -> result=0x0000, Z=1, C=V=1, error=2.
- Backpressure: hold out_ready=0 for 5 cycles after an OR of 0x00F0 and 0x0F00 -> result stays 0x0FF0; in_ready=0; a pulsed in_valid with op=ADD is ignored. Release out_ready -> IDLE, in_ready=1 the following cycle.
- Reset after 5 EXEC cycles of a MUL -> out_valid, result, flags and error go to 0 immediately. After release, AND a=0xF0F0, b=0x0FF0 -> result=0x00F0, error=0.
- op=7 with a=0x1234, b=0x5678 -> result=0x0000, Z=1, error=3, latency 1 cycle.
